// File: rtl/commit_rename_table.sv
// Committed architectural-to-physical register map: frees superseded physical
// registers on retire and replays the whole map after a pipeline flush.
module commit_rename_table #(
   parameter int NUM_WB_GROUPS = 2,
   parameter bit RENAME_ZERO   = 1'b0,
   localparam int GW = (NUM_WB_GROUPS > 2) ? $clog2(NUM_WB_GROUPS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          retire_valid,
   input  logic [4:0]    retire_rd_addr,
   input  logic [5:0]    retire_phys_addr,
   input  logic [GW-1:0] retire_wb_group,
   output logic          free_valid,
   output logic [5:0]    free_phys_addr,
   input  logic          restore_req,
   output logic          restore_valid,
   output logic [4:0]    restore_rd_addr,
   output logic [5:0]    restore_phys_addr,
   output logic [GW-1:0] restore_wb_group,
   output logic          restore_done,
   output logic          ready
);
   localparam int EW = 6 + GW;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_RESTORE} state_t;

   state_t        state_q, state_d;
   logic [4:0]    idx_q, idx_d;
   logic          free_valid_q, free_valid_d;
   logic [5:0]    free_phys_q, free_phys_d;

   logic [EW-1:0] map_q [32];
   logic          map_we;
   logic [4:0]    map_waddr;
   logic [EW-1:0] map_wdata;

   logic          retire_take;
   logic [5:0]    old_phys;
   logic [EW-1:0] restore_entry;

   assign retire_take   = (state_q == S_IDLE) && retire_valid &&
                          (RENAME_ZERO || (retire_rd_addr != 5'd0));
   assign old_phys      = map_q[retire_rd_addr][EW-1 -: 6];
   assign restore_entry = map_q[idx_q];

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      free_valid_d = 1'b0;
      free_phys_d  = free_phys_q;
      map_we       = 1'b0;
      map_waddr    = retire_rd_addr;
      map_wdata    = {retire_phys_addr, retire_wb_group};
      case (state_q)
         S_INIT: begin
            // Identity map: architectural register i lives in physical register i.
            map_we    = 1'b1;
            map_waddr = idx_q;
            map_wdata = {1'b0, idx_q, {GW{1'b0}}};
            idx_d     = idx_q + 5'd1;
            if (idx_q == 5'd31) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (retire_take) begin
               map_we       = 1'b1;
               free_valid_d = 1'b1;
               free_phys_d  = old_phys;
            end
            if (restore_req) begin
               idx_d   = 5'd0;
               state_d = S_RESTORE;
            end
         end
         S_RESTORE: begin
            if (restore_req) begin
               idx_d = 5'd0;
            end else begin
               idx_d = idx_q + 5'd1;
               if (idx_q == 5'd31) state_d = S_IDLE;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_INIT;
         idx_q        <= 5'd0;
         free_valid_q <= 1'b0;
         free_phys_q  <= 6'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         free_valid_q <= free_valid_d;
         free_phys_q  <= free_phys_d;
      end
   end

   always_ff @(posedge clk) begin
      if (map_we && !rst) map_q[map_waddr] <= map_wdata;
   end

   assign free_valid        = free_valid_q;
   assign free_phys_addr    = free_phys_q;
   assign ready             = (state_q == S_IDLE);
   assign restore_valid     = (state_q == S_RESTORE);
   assign restore_done      = (state_q == S_RESTORE) && (idx_q == 5'd31);
   assign restore_rd_addr   = idx_q;
   assign restore_phys_addr = restore_entry[EW-1 -: 6];
   assign restore_wb_group  = restore_entry[GW-1:0];

   // Retires are only legal while the map is quiescent.
   retire_in_restore_a: assert property (@(posedge clk) disable iff (rst)
      !((state_q == S_RESTORE) && retire_valid));

endmodule

// File: tb/tb_commit_rename_table.sv
// Bench for commit_rename_table: two instances (x0 fixed / x0 renamed) share
// stimulus and are compared against an array model of the committed map.
module tb_commit_rename_table;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       retire_valid = 1'b0;
   logic [4:0] retire_rd_addr = 5'd0;
   logic [5:0] retire_phys_addr = 6'd0;
   logic [0:0] retire_wb_group = 1'b0;
   logic       restore_req = 1'b0;

   logic [1:0]      fv, rv, rdone, rdy;
   logic [1:0][5:0] fp, rph;
   logic [1:0][4:0] rrd;
   logic [1:0][0:0] rgr;

   int passed = 0;
   int total  = 0;

   int mphys [2][32];
   int mgrp  [2][32];
   logic [1:0] exp_fv;
   int         exp_fp [2];
   int         pool [$];

   always #5 clk = ~clk;

   commit_rename_table #(.NUM_WB_GROUPS(2), .RENAME_ZERO(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_rd_addr(retire_rd_addr),
      .retire_phys_addr(retire_phys_addr), .retire_wb_group(retire_wb_group),
      .free_valid(fv[0]), .free_phys_addr(fp[0]), .restore_req(restore_req),
      .restore_valid(rv[0]), .restore_rd_addr(rrd[0]), .restore_phys_addr(rph[0]),
      .restore_wb_group(rgr[0]), .restore_done(rdone[0]), .ready(rdy[0]));

   commit_rename_table #(.NUM_WB_GROUPS(2), .RENAME_ZERO(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_rd_addr(retire_rd_addr),
      .retire_phys_addr(retire_phys_addr), .retire_wb_group(retire_wb_group),
      .free_valid(fv[1]), .free_phys_addr(fp[1]), .restore_req(restore_req),
      .restore_valid(rv[1]), .restore_rd_addr(rrd[1]), .restore_phys_addr(rph[1]),
      .restore_wb_group(rgr[1]), .restore_done(rdone[1]), .ready(rdy[1]));

   task automatic chk(input string tag, input int u, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s (inst %0d) observed=%0d expected=%0d", tag, u, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Spec-level retire effect on both maps; x0 is frozen only in instance 0.
   task automatic model_retire(input int rd, input int ph, input int gr);
      for (int u = 0; u < 2; u++) begin
         if (u == 1 || rd != 0) begin
            exp_fv[u]   = 1'b1;
            exp_fp[u]   = mphys[u][rd];
            mphys[u][rd] = ph;
            mgrp[u][rd]  = gr;
         end else begin
            exp_fv[u] = 1'b0;
            exp_fp[u] = 0;
         end
      end
   endtask

   task automatic check_free(input string tag);
      for (int u = 0; u < 2; u++) begin
         chk({tag, "_free_valid"}, u, 32'(fv[u]), 32'(exp_fv[u]));
         if (exp_fv[u]) chk({tag, "_free_phys"}, u, 32'(fp[u]), exp_fp[u]);
      end
   endtask

   task automatic drive_retire(input int rd, input int ph, input int gr);
      retire_valid     = 1'b1;
      retire_rd_addr   = 5'(rd);
      retire_phys_addr = 6'(ph);
      retire_wb_group  = 1'(gr);
      model_retire(rd, ph, gr);
   endtask

   task automatic retire_one(input int rd, input int ph, input int gr);
      drive_retire(rd, ph, gr);
      tick();
      check_free($sformatf("retire_rd%0d", rd));
      retire_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      retire_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         tick();
         for (int u = 0; u < 2; u++) begin
            chk("idle_free_valid", u, 32'(fv[u]), 0);
            chk("idle_ready", u, 32'(rdy[u]), 1);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      retire_valid = 1'b0;
      restore_req = 1'b0;
      tick();
      rst = 1'b0;
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 32; i++) begin
            mphys[u][i] = i;
            mgrp[u][i]  = 0;
         end
         chk("reset_free_valid", u, 32'(fv[u]), 0);
         chk("reset_free_phys", u, 32'(fp[u]), 0);
         chk("reset_restore_valid", u, 32'(rv[u]), 0);
         chk("reset_restore_done", u, 32'(rdone[u]), 0);
      end
      // Requests during INIT must be ignored.
      for (int k = 0; k < 32; k++) begin
         for (int u = 0; u < 2; u++) begin
            chk("init_ready", u, 32'(rdy[u]), 0);
            chk("init_restore_valid", u, 32'(rv[u]), 0);
            chk("init_free_valid", u, 32'(fv[u]), 0);
         end
         if (k < 31) begin
            restore_req      = 1'($urandom_range(0, 1));
            retire_valid     = 1'($urandom_range(0, 1));
            retire_rd_addr   = 5'($urandom_range(0, 31));
            retire_phys_addr = 6'($urandom_range(32, 63));
         end else begin
            restore_req  = 1'b0;
            retire_valid = 1'b0;
         end
         tick();
      end
      for (int u = 0; u < 2; u++) chk("init_ready_rise", u, 32'(rdy[u]), 1);
   endtask

   task automatic restore_walk(input int restart_at, input int abort_at, input bit with_ret,
                               input int rd, input int ph, input int gr);
      int  i;
      bit  restarted;
      bit  first;
      restore_req = 1'b1;
      if (with_ret) drive_retire(rd, ph, gr);
      tick();
      restore_req  = 1'b0;
      retire_valid = 1'b0;
      if (with_ret) check_free("restore_concurrent");
      i = 0;
      restarted = 1'b0;
      first = 1'b1;
      while (i < 32) begin
         if (i == abort_at) begin
            do_reset();
            return;
         end
         for (int u = 0; u < 2; u++) begin
            chk($sformatf("restore%0d_valid", i), u, 32'(rv[u]), 1);
            chk($sformatf("restore%0d_rd", i), u, 32'(rrd[u]), i);
            chk($sformatf("restore%0d_phys", i), u, 32'(rph[u]), mphys[u][i]);
            chk($sformatf("restore%0d_group", i), u, 32'(rgr[u]), mgrp[u][i]);
            chk($sformatf("restore%0d_done", i), u, 32'(rdone[u]), (i == 31) ? 1 : 0);
            chk($sformatf("restore%0d_ready", i), u, 32'(rdy[u]), 0);
            if (!(first && with_ret)) chk($sformatf("restore%0d_free_valid", i), u, 32'(fv[u]), 0);
         end
         first = 1'b0;
         if (!restarted && i == restart_at) begin
            restore_req = 1'b1;
            tick();
            restore_req = 1'b0;
            restarted = 1'b1;
            i = 0;
         end else begin
            tick();
            i++;
         end
      end
      for (int u = 0; u < 2; u++) begin
         chk("restore_end_ready", u, 32'(rdy[u]), 1);
         chk("restore_end_valid", u, 32'(rv[u]), 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd, ph, k, r;
      // Reset, INIT and identity replay
      do_reset();
      restore_walk(-1, -1, 1'b0, 0, 0, 0);
      // Back-to-back retires to the same rd
      retire_one(5, 40, 1);
      retire_one(5, 41, 0);
      idle(1);
      // Restore after several retires
      retire_one(3, 33, 0);
      retire_one(7, 39, 1);
      retire_one(3, 45, 1);
      idle(2);
      restore_walk(-1, -1, 1'b0, 0, 0, 0);
      // Restart mid-walk, then retire concurrent with restore_req
      restore_walk(10, -1, 1'b0, 0, 0, 0);
      restore_walk(-1, -1, 1'b1, 9, 60, 1);
      // x0 handling differs between the two instances
      retire_one(0, 50, 1);
      restore_walk(-1, -1, 1'b0, 0, 0, 0);
      // Reset at restore index 20, then identity again
      restore_walk(-1, 20, 1'b0, 0, 0, 0);
      restore_walk(-1, -1, 1'b0, 0, 0, 0);
      // Random retires drawing from a free pool keep committed phys distinct
      pool.delete();
      for (int p = 32; p < 64; p++) pool.push_back(p);
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 19);
         if (r < 14) begin
            rd = $urandom_range(1, 31);
            k  = $urandom_range(0, pool.size() - 1);
            ph = pool[k];
            pool.delete(k);
            pool.push_back(mphys[0][rd]);
            retire_one(rd, ph, $urandom_range(0, 1));
         end else if (r < 19) begin
            idle(1);
         end else begin
            restore_walk(-1, -1, 1'b0, 0, 0, 0);
         end
      end
      restore_walk(-1, -1, 1'b0, 0, 0, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
